// File: rtl/parametric_alu.sv
// rtl/parametric_alu.sv - Width-parametric ALU with narrow/full mode and iterative MUL/DIV
// Single-cycle ops finish on the accept edge; MUL/DIV iterate W cycles in RUN.
module parametric_alu #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       FunSel,
  input  logic             WF,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic [3:0]       FlagsOut
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MASK_F = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MASK_N = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] TOP_F  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TOP_N  = MASK_N ^ (MASK_N >> 1);
  localparam logic [WIDTH:0]   CBIT_F = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   CBIT_N = {1'b0, TOP_N} << 1;

  state_t             state;
  logic [CW-1:0]      cnt, last;
  logic               div_r, wf_r, mode_r;
  logic [WIDTH-1:0]   mask_r, top_r, b_r, mplier, quo, rem;
  logic [2*WIDTH-1:0] prod, mcand;

  logic [WIDTH-1:0]   mask_in, top_in, a_in, b_in, res;
  logic [WIDTH:0]     cbit_in, sum;
  logic               a_msb, b_msb, s_msb, c_n, o_n, op_valid, is_md;

  // Operands are masked to the effective width, so msb/carry are picked with one-hot masks.
  always_comb begin
    mask_in  = FunSel[5] ? MASK_F : MASK_N;
    top_in   = FunSel[5] ? TOP_F : TOP_N;
    cbit_in  = FunSel[5] ? CBIT_F : CBIT_N;
    a_in     = A & mask_in;
    b_in     = B & mask_in;
    a_msb    = |(a_in & top_in);
    b_msb    = |(b_in & top_in);
    is_md    = (FunSel[4:0] == 5'd16) || (FunSel[4:0] == 5'd17);
    sum      = '0;
    s_msb    = 1'b0;
    res      = '0;
    c_n      = FlagsOut[2];
    o_n      = FlagsOut[0];
    op_valid = 1'b1;
    case (FunSel[4:0])
      5'd0:  res = a_in;
      5'd1:  res = b_in;
      5'd2:  res = ~a_in & mask_in;
      5'd3:  res = ~b_in & mask_in;
      5'd4, 5'd5: begin
        sum   = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, FunSel[0] & FlagsOut[2]};
        res   = sum[WIDTH-1:0] & mask_in;
        s_msb = |(sum[WIDTH-1:0] & top_in);
        c_n   = |(sum & cbit_in);
        o_n   = (a_msb == b_msb) && (s_msb != a_msb);
      end
      5'd6: begin
        sum   = {1'b0, a_in} - {1'b0, b_in};
        res   = sum[WIDTH-1:0] & mask_in;
        s_msb = |(sum[WIDTH-1:0] & top_in);
        c_n   = (a_in >= b_in);
        o_n   = (a_msb != b_msb) && (s_msb != a_msb);
      end
      5'd7:  res = a_in & b_in;
      5'd8:  res = a_in | b_in;
      5'd9:  res = a_in ^ b_in;
      5'd10: res = ~(a_in & b_in) & mask_in;
      5'd11: begin res = (a_in << 1) & mask_in; c_n = a_msb; end
      5'd12: begin res = a_in >> 1; c_n = a_in[0]; end
      5'd13: begin res = (a_in >> 1) | (a_msb ? top_in : '0); c_n = a_in[0]; end
      5'd14: begin
        res = ((a_in << 1) | {{(WIDTH-1){1'b0}}, FlagsOut[2]}) & mask_in;
        c_n = a_msb;
      end
      5'd15: begin res = (a_in >> 1) | (FlagsOut[2] ? top_in : '0); c_n = a_in[0]; end
      default: op_valid = 1'b0;
    endcase
  end

  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx, md_lo, md_hi;

  // One shift-add / restoring-divide step; the last step's result goes straight to the outputs.
  always_comb begin
    last    = mode_r ? CW'(WIDTH - 1) : CW'(HALF - 1);
    prod_nx = mplier[0] ? prod + mcand : prod;
    rem_sh  = {rem, |(quo & top_r)};
    ge      = rem_sh >= {1'b0, b_r};
    rem_nx  = ge ? rem_sh[WIDTH-1:0] - b_r : rem_sh[WIDTH-1:0];
    quo_nx  = ((quo << 1) | {{(WIDTH-1){1'b0}}, ge}) & mask_r;
    if (div_r) begin
      md_lo = quo_nx;
      md_hi = rem_nx;
    end else begin
      md_lo = prod_nx[WIDTH-1:0] & mask_r;
      md_hi = (mode_r ? prod_nx[WIDTH +: WIDTH] : prod_nx[HALF +: WIDTH]) & mask_r;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE; Busy <= 1'b0; Done <= 1'b0;
      ALUOut <= '0; ALUOutHi <= '0; FlagsOut <= 4'b0000;
      cnt <= '0; div_r <= 1'b0; wf_r <= 1'b0; mode_r <= 1'b0;
      mask_r <= '0; top_r <= '0; b_r <= '0;
      mplier <= '0; quo <= '0; rem <= '0; prod <= '0; mcand <= '0;
    end else begin
      case (state)
        RUN: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == last) begin
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            ALUOut   <= md_lo;
            ALUOutHi <= md_hi;
            if (wf_r)
              FlagsOut <= {md_lo == '0, FlagsOut[2], |(md_lo & top_r),
                           div_r ? (b_r == '0) : (md_hi != '0)};
          end
        end
        default: begin
          state <= IDLE;
          Done  <= 1'b0;
          if (Start) begin
            if (is_md) begin
              state  <= RUN;
              Busy   <= 1'b1;
              div_r  <= FunSel[0];
              wf_r   <= WF;
              mode_r <= FunSel[5];
              mask_r <= mask_in;
              top_r  <= top_in;
              b_r    <= b_in;
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_in};
              mplier <= b_in;
              rem    <= '0;
              quo    <= a_in;
              cnt    <= '0;
            end else begin
              state    <= DONE;
              Done     <= 1'b1;
              ALUOut   <= res;
              ALUOutHi <= '0;
              if (WF && op_valid)
                FlagsOut <= {res == '0, c_n, |(res & top_in), o_n};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parametric_alu.sv
// tb/tb_parametric_alu.sv - Directed scoreboard bench for parametric_alu at WIDTH=16
module tb_parametric_alu;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [5:0]  FunSel = '0;
  logic        WF = 1'b0;
  logic        Start = 1'b0;
  logic        Busy, Done;
  logic [15:0] ALUOut, ALUOutHi;
  logic [3:0]  FlagsOut;

  parametric_alu #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
    .Start(Start), .Busy(Busy), .Done(Done), .ALUOut(ALUOut),
    .ALUOutHi(ALUOutHi), .FlagsOut(FlagsOut)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] out;
    logic [15:0] hi;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are scrambled after acceptance; poke issues a stray Start while the DUT is busy.
  task automatic run_op(input string tag, input logic [5:0] fs, input logic [15:0] a,
                        input logic [15:0] b, input logic wf, input logic [15:0] eo,
                        input logic [15:0] eh, input logic [3:0] ef, input int lat,
                        input bit poke);
    exp_t  e;
    string t;
    int    n, busy_n;
    sb.push_back('{eo, eh, ef, lat});
    tags.push_back(tag);
    @(negedge Clock);
    A = a; B = b; FunSel = fs; WF = wf; Start = 1'b1;
    n = 0;
    busy_n = 0;
    do begin
      @(negedge Clock);
      Start = 1'b0;
      A = ~a; B = ~b; WF = ~wf; FunSel = fs ^ 6'h20;
      n++;
      if (Busy) busy_n++;
      if (poke && n == 3) begin
        Start = 1'b1;
        FunSel = 6'h24;
      end
    end while (!Done && n < 40);
    e = sb.pop_front();
    t = tags.pop_front();
    check({t, "_done"}, 32'(Done), 32'd1);
    check({t, "_lat"}, 32'(n), 32'(e.lat));
    check({t, "_busy"}, 32'(busy_n), 32'(e.lat - 1));
    check({t, "_out"}, 32'(ALUOut), 32'(e.out));
    check({t, "_hi"}, 32'(ALUOutHi), 32'(e.hi));
    check({t, "_flags"}, 32'(FlagsOut), 32'(e.flags));
  endtask

  initial begin
    exp_t e;
    int   done_n, busy_n;

    repeat (2) @(negedge Clock);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_out", 32'(ALUOut), 32'd0);
    check("rst_hi", 32'(ALUOutHi), 32'd0);
    check("rst_flags", 32'(FlagsOut), 32'd0);
    Reset = 1'b1;

    run_op("add_full",  6'h24, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 4'b1100, 1,  1'b0);
    run_op("sub_nar",   6'h06, 16'h1280, 16'h0001, 1'b1, 16'h007F, 16'h0000, 4'b0101, 1,  1'b0);
    run_op("sub_nowf",  6'h06, 16'h1280, 16'h0001, 1'b0, 16'h007F, 16'h0000, 4'b0101, 1,  1'b0);
    run_op("mul_full",  6'h30, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'hFFFE, 4'b0101, 17, 1'b1);
    run_op("div_nar",   6'h11, 16'h0064, 16'h0007, 1'b1, 16'h000E, 16'h0002, 4'b0100, 9,  1'b0);
    run_op("div_zero",  6'h11, 16'h0064, 16'h0000, 1'b1, 16'h00FF, 16'h0064, 4'b0111, 9,  1'b0);
    run_op("rol_nar",   6'h0E, 16'h0080, 16'h0000, 1'b1, 16'h0001, 16'h0000, 4'b0101, 1,  1'b0);
    run_op("reserved",  6'h3F, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 4'b0101, 1,  1'b0);
    run_op("adc_nar",   6'h05, 16'h0001, 16'h0001, 1'b1, 16'h0003, 16'h0000, 4'b0000, 1,  1'b0);
    run_op("asr_full",  6'h2D, 16'h8001, 16'h0000, 1'b1, 16'hC000, 16'h0000, 4'b0110, 1,  1'b0);
    run_op("ror_nar",   6'h0F, 16'h0002, 16'h0000, 1'b1, 16'h0081, 16'h0000, 4'b0010, 1,  1'b0);
    run_op("mul_nar",   6'h10, 16'hAB12, 16'hCD34, 1'b1, 16'h00A8, 16'h0003, 4'b0011, 9,  1'b0);

    // Two single-cycle ops back to back: Done must stay high for both.
    sb.push_back('{16'h1234, 16'h0000, 4'b0001, 1});
    sb.push_back('{16'hFF00, 16'h0000, 4'b0011, 1});
    @(negedge Clock);
    A = 16'h1234; B = 16'h0000; FunSel = 6'h20; WF = 1'b1; Start = 1'b1;
    @(negedge Clock);
    e = sb.pop_front();
    check("b2b1_done", 32'(Done), 32'd1);
    check("b2b1_out", 32'(ALUOut), 32'(e.out));
    check("b2b1_flags", 32'(FlagsOut), 32'(e.flags));
    A = 16'h0000; B = 16'h00FF; FunSel = 6'h23;
    @(negedge Clock);
    Start = 1'b0;
    e = sb.pop_front();
    check("b2b2_done", 32'(Done), 32'd1);
    check("b2b2_out", 32'(ALUOut), 32'(e.out));
    check("b2b2_flags", 32'(FlagsOut), 32'(e.flags));
    @(negedge Clock);
    check("b2b_end_done", 32'(Done), 32'd0);

    // Reset during MUL RUN aborts; Start held while in reset is ignored.
    A = 16'h0003; B = 16'h0005; FunSel = 6'h30; WF = 1'b1; Start = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    check("abort_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b0;
    Start = 1'b1;
    FunSel = 6'h24;
    @(negedge Clock);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_out", 32'(ALUOut), 32'd0);
    check("abort_hi", 32'(ALUOutHi), 32'd0);
    check("abort_flags", 32'(FlagsOut), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    Start = 1'b0;
    done_n = 0;
    busy_n = 0;
    repeat (25) begin
      @(negedge Clock);
      if (Done) done_n++;
      if (Busy) busy_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    check("abort_no_busy", 32'(busy_n), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
